// File: rtl/matrix_row_collector.sv
// matrix_row_collector: captures N result rows of N x W bits from the matrix
// multiplier into a row bank, then streams the completed matrix back in index
// order with a valid/ready handshake for the next rotation pass.
//
//  state      | meaning
//  -----------+-----------------------------------------------------------
//  ST_COLLECT | accepting row writes until every bitmap bit is set
//  ST_FULL    | all rows held, matrix_ready=1, waiting for rd_start
//  ST_READOUT | streaming rows 0..N-1, one per accepted handshake
module matrix_row_collector #(
  parameter int N  = 32,
  parameter int W  = 32,
  parameter int AW = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            write_data,
  input  logic [AW-1:0]   out_address,
  input  logic [N*W-1:0]  out,
  input  logic            select_line_out,
  input  logic            rd_start,
  input  logic            rd_ready,
  output logic            matrix_ready,
  output logic            rd_valid,
  output logic [N*W-1:0]  rd_row,
  output logic [AW-1:0]   rd_index,
  output logic            rd_select,
  output logic [AW:0]     rows_filled,
  output logic            err
);

  typedef enum logic [1:0] {
    ST_COLLECT,
    ST_FULL,
    ST_READOUT
  } state_t;

  // Addresses at or above N can only occur when N does not fill the address space.
  localparam bit ADDR_SPARSE = (N < (1 << AW));

  state_t          state_q, state_d;
  logic [N-1:0]    bitmap_q, bitmap_d;
  logic [AW:0]     rows_filled_q, rows_filled_d;
  logic            tag_q, tag_d;
  logic            err_q, err_d;
  logic            rd_valid_q, rd_valid_d;
  logic [AW-1:0]   rd_index_q, rd_index_d;
  logic [N*W-1:0]  rd_row_q, rd_row_d;
  logic [N*W-1:0]  bank_q [N];

  logic            bank_we;
  logic            rd_load;
  logic [AW-1:0]   rd_addr;
  logic            addr_ok;
  logic            tag_ok;
  logic [N-1:0]    wr_onehot;

  assign addr_ok   = !ADDR_SPARSE || (int'(out_address) < N);
  assign wr_onehot = {{(N-1){1'b0}}, 1'b1} << out_address;
  // The tag is free to be latched while the bitmap is empty; otherwise it must match.
  assign tag_ok    = (bitmap_q == '0) || (select_line_out == tag_q);

  // Next-state and datapath control; every target defaults to holding its value.
  always_comb begin
    state_d       = state_q;
    bitmap_d      = bitmap_q;
    rows_filled_d = rows_filled_q;
    tag_d         = tag_q;
    err_d         = err_q;
    rd_valid_d    = rd_valid_q;
    rd_index_d    = rd_index_q;
    bank_we       = 1'b0;
    rd_load       = 1'b0;
    rd_addr       = rd_index_q;

    unique case (state_q)
      ST_COLLECT: begin
        if (write_data) begin
          if (!addr_ok || !tag_ok) begin
            err_d = 1'b1;
          end else begin
            bank_we  = 1'b1;
            bitmap_d = bitmap_q | wr_onehot;
            if (bitmap_q == '0) tag_d = select_line_out;
            if ((bitmap_q & wr_onehot) == '0) rows_filled_d = rows_filled_q + (AW+1)'(1);
            if (&bitmap_d) state_d = ST_FULL;
          end
        end
      end
      ST_FULL: begin
        if (write_data) err_d = 1'b1;
        if (rd_start) begin
          state_d    = ST_READOUT;
          rd_valid_d = 1'b1;
          rd_index_d = '0;
          rd_addr    = '0;
          rd_load    = 1'b1;
        end
      end
      ST_READOUT: begin
        if (write_data) err_d = 1'b1;
        if (rd_valid_q && rd_ready) begin
          if (rd_index_q == AW'(N-1)) begin
            rd_valid_d    = 1'b0;
            bitmap_d      = '0;
            rows_filled_d = '0;
            state_d       = ST_COLLECT;
          end else begin
            rd_index_d = rd_index_q + AW'(1);
            rd_addr    = rd_index_d;
            rd_load    = 1'b1;
          end
        end
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  assign rd_row_d = rd_load ? bank_q[rd_addr] : rd_row_q;

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_COLLECT;
      bitmap_q      <= '0;
      rows_filled_q <= '0;
      tag_q         <= 1'b0;
      err_q         <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_index_q    <= '0;
      rd_row_q      <= '0;
    end else begin
      state_q       <= state_d;
      bitmap_q      <= bitmap_d;
      rows_filled_q <= rows_filled_d;
      tag_q         <= tag_d;
      err_q         <= err_d;
      rd_valid_q    <= rd_valid_d;
      rd_index_q    <= rd_index_d;
      rd_row_q      <= rd_row_d;
    end
  end

  // Row bank: no reset, contents are only meaningful once the bitmap says so.
  always_ff @(posedge clk) begin
    if (bank_we && !reset) bank_q[out_address] <= out;
  end

  assign matrix_ready = (state_q == ST_FULL);
  assign rd_valid     = rd_valid_q;
  assign rd_row       = rd_row_q;
  assign rd_index     = rd_index_q;
  assign rd_select    = tag_q;
  assign rows_filled  = rows_filled_q;
  assign err          = err_q;

endmodule

// File: tb/tb_matrix_row_collector.sv
// Self-checking bench for matrix_row_collector: randomized row captures and
// readouts compared against an array-based model of the capture/readout rules.
module tb_matrix_row_collector;
  localparam int N  = 32;
  localparam int W  = 32;
  localparam int AW = 5;
  localparam int M_COLLECT = 0;
  localparam int M_FULL    = 1;
  localparam int M_READOUT = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            write_data;
  logic [AW-1:0]   out_address;
  logic [N*W-1:0]  out;
  logic            select_line_out;
  logic            rd_start;
  logic            rd_ready;
  logic            matrix_ready;
  logic            rd_valid;
  logic [N*W-1:0]  rd_row;
  logic [AW-1:0]   rd_index;
  logic            rd_select;
  logic [AW:0]     rows_filled;
  logic            err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [N*W-1:0] m_bank [N];
  bit             m_have [N];
  int             m_filled;
  bit             m_tag;
  bit             m_err;
  int             m_mode;

  always #5 clk = ~clk;

  matrix_row_collector #(.N(N), .W(W), .AW(AW)) dut (
    .clk(clk), .reset(reset), .write_data(write_data), .out_address(out_address),
    .out(out), .select_line_out(select_line_out), .rd_start(rd_start), .rd_ready(rd_ready),
    .matrix_ready(matrix_ready), .rd_valid(rd_valid), .rd_row(rd_row), .rd_index(rd_index),
    .rd_select(rd_select), .rows_filled(rows_filled), .err(err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*W-1:0] rand_row();
    logic [N*W-1:0] r;
    for (int k = 0; k < N; k++) r[k*W +: W] = $urandom;
    return r;
  endfunction

  task automatic check_status(input string tag);
    chk({tag, "_filled"}, rows_filled, m_filled);
    chk({tag, "_err"}, err, m_err);
    chk({tag, "_mready"}, matrix_ready, (m_mode == M_FULL));
    chk({tag, "_rvalid"}, rd_valid, (m_mode == M_READOUT));
  endtask

  task automatic do_reset();
    reset = 1'b1; write_data = 1'b0; rd_start = 1'b0; rd_ready = 1'b0;
    step();
    for (int k = 0; k < N; k++) m_have[k] = 1'b0;
    m_filled = 0; m_tag = 1'b0; m_err = 1'b0; m_mode = M_COLLECT;
    chk("rst_mready", matrix_ready, 0);
    chk("rst_rvalid", rd_valid, 0);
    chk("rst_row", (rd_row == '0), 1);
    chk("rst_index", rd_index, 0);
    chk("rst_select", rd_select, 0);
    chk("rst_filled", rows_filled, 0);
    chk("rst_err", err, 0);
    reset = 1'b0;
  endtask

  // One write cycle; model applies the capture/drop rules.
  task automatic wr(input int addr, input logic [N*W-1:0] data, input bit tag);
    out_address = AW'(addr); out = data; select_line_out = tag; write_data = 1'b1;
    step();
    write_data = 1'b0;
    if (m_mode != M_COLLECT) m_err = 1'b1;
    else if (m_filled != 0 && tag != m_tag) m_err = 1'b1;
    else begin
      if (m_filled == 0) m_tag = tag;
      m_bank[addr] = data;
      if (!m_have[addr]) begin
        m_have[addr] = 1'b1;
        m_filled++;
      end
      if (m_filled == N) m_mode = M_FULL;
    end
    check_status("wr");
  endtask

  // Random addresses (repeats included) until the model says the matrix is complete.
  task automatic fill_rand(input bit tag);
    int it = 0;
    while (m_filled < N && it < 3000) begin
      wr($urandom_range(0, N-1), rand_row(), tag);
      it++;
    end
    chk("fill_done", rows_filled, N);
  endtask

  task automatic readout(input int stall_at, input bit rnd, input int wr_at,
                         input int abort_at, input bit wr_with_start);
    int  idx = 0;
    int  stall = 0;
    int  cyc = 0;
    bit  rdy;
    bit  wrote = 1'b0;
    rd_start = 1'b1;
    if (wr_with_start) begin
      write_data = 1'b1; out_address = AW'(3); out = rand_row(); select_line_out = m_tag;
      if (m_mode != M_COLLECT) m_err = 1'b1;
    end
    step();
    rd_start = 1'b0; write_data = 1'b0;
    if (m_mode == M_FULL) m_mode = M_READOUT;
    while (idx < N && cyc < 400) begin
      chk("rd_valid", rd_valid, 1);
      chk("rd_index", rd_index, idx);
      chk("rd_select", rd_select, m_tag);
      chk("rd_mready", matrix_ready, 0);
      chk("rd_err", err, m_err);
      for (int k = 0; k < N; k++) chk("rd_row", rd_row[k*W +: W], m_bank[idx][k*W +: W]);
      if (idx == abort_at) begin
        do_reset();
        return;
      end
      rdy = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (idx == stall_at && stall < 3) begin
        rdy = 1'b0;
        stall++;
      end
      rd_ready = rdy;
      if (idx == wr_at && !wrote) begin
        write_data = 1'b1; out_address = AW'($urandom_range(0, N-1)); out = rand_row();
        wrote = 1'b1; m_err = 1'b1;
      end
      step();
      write_data = 1'b0; rd_ready = 1'b0;
      if (rdy) idx++;
      cyc++;
    end
    chk("rd_timeout", idx, N);
    if (!rnd) chk("rd_cycles", cyc, N + ((stall_at >= 0) ? 3 : 0));
    for (int k = 0; k < N; k++) m_have[k] = 1'b0;
    m_filled = 0;
    m_mode = M_COLLECT;
    chk("rd_done_valid", rd_valid, 0);
    check_status("rd_done");
  endtask

  initial begin
    reset = 1'b1; write_data = 1'b0; out_address = '0; out = '0;
    select_line_out = 1'b0; rd_start = 1'b0; rd_ready = 1'b0;
    do_reset();

    // Ascending capture with row k = element value k+1, tag 0, then straight readout.
    for (int k = 0; k < N; k++) begin
      wr(k, {N{W'(k+1)}}, 1'b0);
      chk("t1_filled", rows_filled, k + 1);
      chk("t1_mready", matrix_ready, (k == N-1));
    end
    chk("t1_err", err, 0);
    readout(-1, 1'b0, -1, -1, 1'b0);

    // Descending capture with a repeat write to row 5.
    for (int k = N-1; k >= 0; k--) begin
      wr(k, rand_row(), 1'b1);
      if (k == 5) wr(5, {N{32'hDEAD_BEEF}}, 1'b1);
      chk("t2_max", (rows_filled <= N), 1);
    end
    chk("t2_filled", rows_filled, N);
    chk("t2_row5", m_bank[5][W-1:0], 32'hDEAD_BEEF);
    readout(-1, 1'b1, -1, -1, 1'b0);

    // Stall at index 7 for three cycles.
    fill_rand(1'b0);
    readout(7, 1'b0, -1, -1, 1'b0);

    for (int r = 0; r < 2; r++) begin
      fill_rand(r[0]);
      readout(-1, 1'b1, -1, -1, 1'b0);
    end
    chk("t_err_clean", err, 0);

    // Write in FULL, then rd_start together with a write: both dropped, readout proceeds.
    fill_rand(1'b1);
    wr(3, rand_row(), m_tag);
    chk("t5_full_err", err, 1);
    readout(-1, 1'b0, -1, -1, 1'b1);

    // Tag mismatch drop.
    do_reset();
    wr(0, rand_row(), 1'b1);
    wr(0, rand_row(), 1'b0);
    chk("t5_tag_err", err, 1);
    chk("t5_tag_filled", rows_filled, 1);
    fill_rand(1'b1);
    readout(-1, 1'b1, -1, -1, 1'b0);

    // Reset with 20 rows captured; rd_start in COLLECT is ignored.
    do_reset();
    for (int k = 0; k < 20; k++) wr(k, rand_row(), 1'b0);
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    chk("t6_start_ignored", rd_valid, 0);
    check_status("t6_collect");
    do_reset();

    // Write during readout, then reset at read index 10, then a normal pass.
    fill_rand(1'b1);
    readout(-1, 1'b0, 3, 10, 1'b0);
    fill_rand(1'b0);
    readout(-1, 1'b1, -1, -1, 1'b0);
    chk("t6_err_final", err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
